// File: rtl/vend_controller.sv
// Vending-machine controller: turns keypad presses into coin/select/cancel
// events, tracks credit, strobes product dispense and pays change as pulses.
module vend_controller #(
    parameter int unsigned PRICE_A     = 3,
    parameter int unsigned PRICE_B     = 5,
    parameter int unsigned PRICE_C     = 7,
    parameter int unsigned PRICE_D     = 10,
    parameter int unsigned CREDIT_MAX  = 15,
    parameter int unsigned DISP_CYCLES = 4,
    parameter int unsigned CHANGE_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_value,
    output logic [4:0] credit,
    output logic [3:0] dispense,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       error,
    output logic       busy,
    output logic [1:0] state
);

    localparam int unsigned DW = $clog2(DISP_CYCLES + 1);
    localparam int unsigned GW = $clog2(CHANGE_GAP + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CREDIT   = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    logic [3:0]    key_prev;
    logic [DW-1:0] disp_cnt;
    logic [GW-1:0] gap_cnt;

    logic [1:0]    state_d;
    logic [4:0]    credit_d;
    logic [3:0]    dispense_d;
    logic          change_pulse_d;
    logic          coin_reject_d;
    logic          error_d;
    logic [DW-1:0] disp_cnt_d;
    logic [GW-1:0] gap_cnt_d;

    logic          evt;
    logic [2:0]    coin_val;
    logic [5:0]    coin_sum;
    logic [4:0]    price;

    // Press detection: only a 0 -> nonzero transition counts as a new key
    assign evt = (key_value != 4'h0) && (key_prev == 4'h0);

    // Coin value and product price decode from the key code
    always_comb begin
        coin_val = 3'd0;
        case (key_value)
            4'h1:    coin_val = 3'd1;
            4'h2:    coin_val = 3'd2;
            4'h3:    coin_val = 3'd5;
            default: coin_val = 3'd0;
        endcase
        case (key_value[1:0])
            2'd0:    price = 5'(PRICE_A);
            2'd1:    price = 5'(PRICE_B);
            2'd2:    price = 5'(PRICE_C);
            default: price = 5'(PRICE_D);
        endcase
        coin_sum = {1'b0, credit} + 6'(coin_val);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        credit_d       = credit;
        dispense_d     = dispense;
        change_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;
        error_d        = 1'b0;
        disp_cnt_d     = disp_cnt;
        gap_cnt_d      = gap_cnt;

        case (state)
            S_IDLE, S_CREDIT: begin
                if (evt) begin
                    case (key_value)
                        4'h1, 4'h2, 4'h3: begin
                            if (coin_sum <= 6'(CREDIT_MAX)) begin
                                credit_d = coin_sum[4:0];
                                state_d  = S_CREDIT;
                            end else begin
                                coin_reject_d = 1'b1;
                            end
                        end
                        4'h4, 4'h5, 4'h6, 4'h7: begin
                            if (credit >= price) begin
                                credit_d   = credit - price;
                                dispense_d = 4'b0001 << key_value[1:0];
                                disp_cnt_d = DW'(DISP_CYCLES - 1);
                                state_d    = S_DISPENSE;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                        4'hC: begin
                            if (credit != 5'd0) begin
                                state_d   = S_CHANGE;
                                gap_cnt_d = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DISPENSE: begin
                if (disp_cnt != '0) begin
                    disp_cnt_d = disp_cnt - DW'(1);
                end else begin
                    dispense_d = 4'b0000;
                    gap_cnt_d  = '0;
                    state_d    = (credit != 5'd0) ? S_CHANGE : S_IDLE;
                end
            end
            default: begin
                if (gap_cnt == '0) begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit - 5'd1;
                    gap_cnt_d      = GW'(CHANGE_GAP);
                    if (credit == 5'd1) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt - GW'(1);
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            credit       <= 5'd0;
            dispense     <= 4'b0000;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
            key_prev     <= 4'h0;
            disp_cnt     <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            dispense     <= dispense_d;
            change_pulse <= change_pulse_d;
            coin_reject  <= coin_reject_d;
            error        <= error_d;
            busy         <= (state_d == S_DISPENSE) || (state_d == S_CHANGE);
            key_prev     <= key_value;
            disp_cnt     <= disp_cnt_d;
            gap_cnt      <= gap_cnt_d;
        end
    end

endmodule
